fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, width of PC and instruction-memory address.
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 Parameter DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 pc_in  in  ADDR_W  current PC from PC stage.
REQ-007 pc_valid  in  1  pc_in is a fetch candidate this cycle.
REQ-008 pc_stall  out  1  PC stage SHALL hold its value this cycle.
REQ-009 flush  in  1  redirect (taken branch/jump); discards all fetched and in-flight instructions.
REQ-010 imem_req  out  1  fetch request, single-cycle pulse.
REQ-011 imem_addr  out  ADDR_W  word-aligned fetch address.
REQ-012 imem_rvalid  in  1  response valid, >=1 cycle after request.
REQ-013 imem_rdata  in  DATA_W  response instruction word.
REQ-014 instr_valid  out  1  buffer head valid toward decode.
REQ-015 instr  out  DATA_W  instruction at buffer head.
REQ-016 instr_pc  out  ADDR_W  PC of instruction at buffer head.
REQ-017 instr_misaligned  out  1  head entry's PC had pc[1:0] != 0.
REQ-018 instr_ready  in  1  decode accepts head this cycle.

Function
REQ-019 FSM states SHALL be IDLE (nothing outstanding), WAIT (one request outstanding), DRAIN (outstanding response to discard).
REQ-020 At most one imem request outstanding at any time.
REQ-021 Request accept condition: pc_valid & !flush & state==IDLE & (count < DEPTH); on accept imem_req=1, imem_addr={pc_in[ADDR_W-1:2],2'b00}, pc_in and misalign bit latched, state->WAIT.
REQ-022 pc_stall = pc_valid & !accept, combinational.
REQ-023 WAIT & imem_rvalid & !flush: write {imem_rdata, latched pc, misalign} to buffer tail, state->IDLE; new request allowed next cycle, not same cycle.
REQ-024 imem_rvalid in IDLE SHALL be ignored (no buffer write).
REQ-025 Buffer is FIFO; head drives instr/instr_pc/instr_misaligned; pop on instr_valid & instr_ready.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-027 Pointers wrap modulo DEPTH; count range 0..DEPTH; push never occurs when count==DEPTH (guaranteed by REQ-021).
REQ-028 instr_valid = (count != 0).
REQ-029 flush: buffer cleared (count=0, pointers 0) at next edge; pop in flush cycle has no effect; from WAIT with no imem_rvalid same cycle -> DRAIN; from WAIT with imem_rvalid same cycle -> IDLE, data dropped; from IDLE/DRAIN state unchanged.
REQ-030 DRAIN & imem_rvalid: data discarded, state->IDLE; no request issued in DRAIN.
REQ-031 Fetch latency: request in cycle N, rvalid in cycle N+k -> instr_valid in cycle N+k+1.
REQ-032 Misaligned PC still fetches the aligned word; instr_misaligned=1 travels with that entry only.

Reset
REQ-033 rst_n low SHALL immediately force state=IDLE, count=0, pointers=0, imem_req=0, instr_valid=0, imem_addr=0, instr=0, instr_pc=0, instr_misaligned=0.
REQ-034 pc_stall = pc_valid during reset assertion; responses arriving during or one cycle after reset release from pre-reset requests are ignored (state IDLE).
REQ-035 Reset mid-operation discards any outstanding request and all buffered entries.

Verification
REQ-036 pc_in=0x0 valid, rvalid 1 cycle later with 0x00500093, instr_ready=1 -> instr_valid next cycle, instr=0x00500093, instr_pc=0x0.
REQ-037 instr_ready=0, PCs 0x0,0x4,0x8 offered -> two entries buffered, pc_stall=1 on 0x8 until a pop; order 0x0,0x4,0x8 preserved.
REQ-038 Request 0x10 outstanding, flush asserted, rvalid 2 cycles later with 0xDEADBEEF -> data discarded, instr_valid stays 0, next request issued after DRAIN exits.
REQ-039 flush with two entries buffered and instr_ready=1 same cycle -> count=0 next cycle, no entry consumed twice.
REQ-040 pc_in=0x6 -> imem_addr=0x4, instr_misaligned=1, instr_pc=0x6.
REQ-041 rst_n low while WAIT with one entry buffered -> outputs zero immediately; late rvalid after release ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one outstanding imem request at a time and queues
// returned words, with their PC and misalignment flag, in a small FIFO toward decode.
module fetch_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_stall,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_misaligned,
    input  logic              instr_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDrain
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              mis_q;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic              mem_mis  [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;

    logic accept;
    logic push;
    logic pop;

    // rst_n gates acceptance so the PC stage is held for the whole reset assertion.
    assign accept = rst_n & pc_valid & ~flush & (state_q == StIdle) & (count_q < CW'(DEPTH));
    assign push   = (state_q == StWait) & imem_rvalid & ~flush;
    assign pop    = instr_valid & instr_ready & ~flush;

    assign pc_stall  = pc_valid & ~accept;
    assign imem_req  = accept;
    assign imem_addr = accept ? {pc_in[ADDR_W-1:2], 2'b00} : '0;

    assign instr_valid      = (count_q != '0);
    assign instr            = instr_valid ? mem_data[rd_ptr_q] : '0;
    assign instr_pc         = instr_valid ? mem_pc[rd_ptr_q] : '0;
    assign instr_misaligned = instr_valid ? mem_mis[rd_ptr_q] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            mis_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StWait;
                        pc_q    <= pc_in;
                        mis_q   <= |pc_in[1:0];
                    end
                end
                // A response in the flush cycle retires the request; data is dropped by push.
                StWait: begin
                    if (imem_rvalid) begin
                        state_q <= StIdle;
                    end else if (flush) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (imem_rvalid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= imem_rdata;
            mem_pc[wr_ptr_q]   <= pc_q;
            mem_mis[wr_ptr_q]  <= mis_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_fetch_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] pc_in = '0;
    logic          pc_valid = 1'b0;
    logic          pc_stall;
    logic          flush = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_rvalid = 1'b0;
    logic [DW-1:0] imem_rdata = '0;
    logic          instr_valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_misaligned;
    logic          instr_ready = 1'b0;

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_in            (pc_in),
        .pc_valid         (pc_valid),
        .pc_stall         (pc_stall),
        .flush            (flush),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .instr_misaligned (instr_misaligned),
        .instr_ready      (instr_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: FIFO of fetched entries, one pending request, one response to discard.
    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] pc;
        logic          m;
    } ent_t;

    ent_t          q[$];
    bit            outst = 0;
    bit            disc  = 0;
    logic [AW-1:0] pend_pc = '0;

    always @(negedge clk) begin
        bit            acc;
        logic [AW-1:0] e_addr;
        ent_t          e;
        if (!rst_n) begin
            q.delete();
            outst = 0;
            disc  = 0;
            chk("rst_pc_stall", 64'(pc_stall), 64'(pc_valid));
            chk("rst_imem_req", 64'(imem_req), 64'd0);
            chk("rst_imem_addr", 64'(imem_addr), 64'd0);
            chk("rst_instr_valid", 64'(instr_valid), 64'd0);
            chk("rst_instr", 64'(instr), 64'd0);
            chk("rst_instr_pc", 64'(instr_pc), 64'd0);
            chk("rst_instr_mis", 64'(instr_misaligned), 64'd0);
        end else begin
            acc    = pc_valid && !flush && !outst && !disc && (q.size() < DEPTH);
            e_addr = acc ? (pc_in & ~32'h3) : '0;
            chk("m_pc_stall", 64'(pc_stall), 64'(pc_valid && !acc));
            chk("m_imem_req", 64'(imem_req), 64'(acc));
            chk("m_imem_addr", 64'(imem_addr), 64'(e_addr));
            chk("m_instr_valid", 64'(instr_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("m_instr", 64'(instr), 64'(q[0].d));
                chk("m_instr_pc", 64'(instr_pc), 64'(q[0].pc));
                chk("m_instr_mis", 64'(instr_misaligned), 64'(q[0].m));
            end
            if (flush) begin
                q.delete();
                if (outst && !imem_rvalid) disc = 1;
                if (disc && imem_rvalid) disc = 0;
                outst = 0;
            end else begin
                if (q.size() != 0 && instr_ready) void'(q.pop_front());
                if (outst && imem_rvalid) begin
                    e.d  = imem_rdata;
                    e.pc = pend_pc;
                    e.m  = (pend_pc[1:0] != 2'b00);
                    q.push_back(e);
                    outst = 0;
                end
                if (disc && imem_rvalid) disc = 0;
                if (acc) begin
                    outst   = 1;
                    pend_pc = pc_in;
                end
            end
        end
    end

    task automatic cyc(input logic pv, input logic [AW-1:0] pc, input logic fl,
                       input logic rv, input logic [DW-1:0] rd, input logic rdy);
        @(posedge clk);
        #1;
        pc_valid    = pv;
        pc_in       = pc;
        flush       = fl;
        imem_rvalid = rv;
        imem_rdata  = rd;
        instr_ready = rdy;
        #3;
    endtask

    initial begin
        pc_valid = 1'b1;
        #3;
        chk("reset_pc_stall", 64'(pc_stall), 64'd1);
        chk("reset_instr_valid", 64'(instr_valid), 64'd0);
        chk("reset_imem_req", 64'(imem_req), 64'd0);
        @(posedge clk);
        #2;
        pc_valid = 1'b0;
        rst_n    = 1'b1;

        // Single fetch, one-cycle response
        cyc(1, 32'h0, 0, 0, 0, 1);
        chk("t1_req", 64'(imem_req), 64'd1);
        chk("t1_addr", 64'(imem_addr), 64'h0);
        cyc(0, 0, 0, 1, 32'h0050_0093, 1);
        chk("t1_not_yet", 64'(instr_valid), 64'd0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t1_valid", 64'(instr_valid), 64'd1);
        chk("t1_instr", 64'(instr), 64'h0050_0093);
        chk("t1_pc", 64'(instr_pc), 64'h0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t1_empty", 64'(instr_valid), 64'd0);

        // Buffer fills with decode stalled; order preserved
        cyc(1, 32'h0, 0, 0, 0, 0);
        cyc(1, 32'h4, 0, 1, 32'hA0, 0);
        chk("t2_wait_stall", 64'(pc_stall), 64'd1);
        cyc(1, 32'h4, 0, 0, 0, 0);
        chk("t2_addr4", 64'(imem_addr), 64'h4);
        cyc(1, 32'h8, 0, 1, 32'hA1, 0);
        cyc(1, 32'h8, 0, 0, 0, 0);
        chk("t2_full_stall", 64'(pc_stall), 64'd1);
        cyc(1, 32'h8, 0, 0, 0, 0);
        chk("t2_head0", 64'(instr_pc), 64'h0);
        cyc(1, 32'h8, 0, 0, 0, 1);
        chk("t2_stall_pop", 64'(pc_stall), 64'd1);
        cyc(1, 32'h8, 0, 0, 0, 0);
        chk("t2_accept8", 64'(imem_addr), 64'h8);
        chk("t2_head4", 64'(instr_pc), 64'h4);
        cyc(0, 0, 0, 1, 32'hA2, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t2_instr4", 64'(instr), 64'hA1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t2_head8", 64'(instr_pc), 64'h8);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t2_empty", 64'(instr_valid), 64'd0);

        // Flush with request outstanding; late response discarded
        cyc(1, 32'h10, 0, 0, 0, 1);
        chk("t3_addr10", 64'(imem_addr), 64'h10);
        cyc(0, 0, 1, 0, 0, 1);
        cyc(1, 32'h20, 0, 0, 0, 1);
        chk("t3_drain_stall", 64'(pc_stall), 64'd1);
        cyc(1, 32'h20, 0, 1, 32'hDEAD_BEEF, 1);
        chk("t3_drain_stall2", 64'(pc_stall), 64'd1);
        cyc(1, 32'h20, 0, 0, 0, 1);
        chk("t3_no_valid", 64'(instr_valid), 64'd0);
        chk("t3_addr20", 64'(imem_addr), 64'h20);
        cyc(0, 0, 0, 1, 32'hB0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t3_instr", 64'(instr), 64'hB0);
        cyc(0, 0, 0, 0, 0, 0);

        // Flush with two buffered entries and a pop in the same cycle
        cyc(1, 32'h40, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h11, 0);
        cyc(1, 32'h44, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h22, 0);
        cyc(0, 0, 1, 0, 0, 1);
        chk("t4_pre_flush", 64'(instr_pc), 64'h40);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t4_flushed", 64'(instr_valid), 64'd0);
        cyc(0, 0, 0, 0, 0, 0);

        // Misaligned PC
        cyc(1, 32'h6, 0, 0, 0, 0);
        chk("t5_addr", 64'(imem_addr), 64'h4);
        cyc(0, 0, 0, 1, 32'h33, 0);
        cyc(1, 32'h8, 0, 0, 0, 0);
        chk("t5_mis", 64'(instr_misaligned), 64'd1);
        chk("t5_pc", 64'(instr_pc), 64'h6);
        cyc(0, 0, 0, 1, 32'h44, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t5_mis_next", 64'(instr_misaligned), 64'd0);
        chk("t5_pc_next", 64'(instr_pc), 64'h8);
        cyc(0, 0, 0, 0, 0, 0);

        // Reset while waiting with one entry buffered
        cyc(1, 32'h80, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h55, 0);
        cyc(1, 32'h84, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        pc_valid    = 1'b1;
        pc_in       = 32'h88;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h77;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid0", 64'(instr_valid), 64'd0);
        chk("t6_req0", 64'(imem_req), 64'd0);
        chk("t6_instr0", 64'(instr), 64'd0);
        chk("t6_pc0", 64'(instr_pc), 64'd0);
        chk("t6_stall", 64'(pc_stall), 64'd1);
        @(posedge clk);
        #2;
        pc_valid = 1'b0;
        rst_n    = 1'b1;
        cyc(0, 0, 0, 1, 32'h66, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t6_late_ignored", 64'(instr_valid), 64'd0);
        cyc(1, 32'h100, 0, 0, 0, 1);
        chk("t6_recover_addr", 64'(imem_addr), 64'h100);
        cyc(0, 0, 0, 1, 32'h99, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t6_recover_instr", 64'(instr), 64'h99);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
